// File: rtl/ram_chk_pkg.sv
// Shared types for the RAM access checker.
// Error codes and the read-pipeline entry layout.
package ram_chk_pkg;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ADDR   = 2'b01;
  localparam logic [1:0] ERR_UNINIT = 2'b10;
  localparam logic [1:0] ERR_DATA   = 2'b11;

  // Fields are sized for the widest supported instance.
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_DATA_W = 32;

  typedef struct packed {
    logic                  vld;
    logic                  written;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/ram_chk_rdpipe.sv
// Read-expectation delay line.
// RD_LAT stages; reset flushes every stage.
module ram_chk_rdpipe #(
  parameter int RD_LAT = 1,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stg [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < RD_LAT; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[RD_LAT-1];

endmodule

// File: rtl/ram_access_checker.sv
// Shadow-model checker for a RAM's access stream.
// Flags bad addresses, uninitialised reads and data mismatches.
module ram_access_checker
  import ram_chk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout,
  input  logic              clr,
  output logic              err_addr,
  output logic              err_uninit,
  output logic              err_data,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_vld,
  output logic [1:0]        first_err_code,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int EW = $bits(rd_entry_t);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  rd_entry_t         push_e;
  rd_entry_t         head;
  logic              in_range;
  logic              ae;
  logic              pe_uninit;
  logic              pe_data;
  logic              pe_any;
  logic [1:0]        n_err;
  logic [CNT_W:0]    cnt_sum;
  logic              unused_head;

  assign in_range = {1'b0, addr} < DEPTH_L;
  assign ae       = en && !in_range;

  always_ff @(posedge clk) begin
    if (en && wr && in_range)
      mem[addr] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset)
      written <= '0;
    else if (en && wr && in_range)
      written[addr] <= 1'b1;
  end

  always_comb begin
    push_e = '0;
    if (en && !wr && in_range) begin
      push_e.vld     = 1'b1;
      push_e.written = written[addr];
      push_e.addr    = MAX_ADDR_W'(addr);
      push_e.data    = MAX_DATA_W'(mem[addr]);
    end
  end

  ram_chk_rdpipe #(
    .RD_LAT (RD_LAT),
    .W      (EW)
  ) u_rdpipe (
    .clk   (clk),
    .reset (reset),
    .din   (push_e),
    .dout  (head)
  );

  assign pe_uninit = head.vld && !head.written;
  assign pe_data   = head.vld && head.written &&
                     (head.data[DATA_W-1:0] != dataout);
  assign pe_any    = pe_uninit || pe_data;
  assign unused_head = ^{head.addr, head.data};

  // Uninit and data errors are exclusive, so at most two per cycle.
  assign n_err   = {1'b0, ae} + {1'b0, pe_any};
  assign cnt_sum = {1'b0, err_cnt} + (CNT_W+1)'(n_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr   <= 1'b0;
      err_uninit <= 1'b0;
      err_data   <= 1'b0;
    end else begin
      err_addr   <= ae;
      err_uninit <= pe_uninit;
      err_data   <= pe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr)
      err_cnt <= '0;
    else if (cnt_sum[CNT_W])
      err_cnt <= '1;
    else
      err_cnt <= cnt_sum[CNT_W-1:0];
  end

  // The pipeline error belongs to the older access, so it wins.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      first_err_vld  <= 1'b0;
      first_err_code <= ERR_NONE;
      first_err_addr <= '0;
    end else if (!first_err_vld && (pe_any || ae)) begin
      first_err_vld <= 1'b1;
      if (pe_any) begin
        first_err_code <= pe_data ? ERR_DATA : ERR_UNINIT;
        first_err_addr <= head.addr[ADDR_W-1:0];
      end else begin
        first_err_code <= ERR_ADDR;
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_checker.sv
// Scoreboard bench for ram_access_checker.
// Three instances: default, CNT_W=2, RD_LAT=3.
module tb_ram_access_checker;

  typedef struct {
    string       tag;
    int          sel;
    logic [2:0]  pul;
    logic [15:0] cnt;
    logic        vld;
    logic [1:0]  code;
    logic [3:0]  fa;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       wr = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] datain = '0;
  logic [7:0] dataout = '0;
  int         sel = 0;
  exp_t       q[$];
  int         n_run = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  logic        ea_a, eu_a, ed_a, fv_a;
  logic [15:0] cnt_a;
  logic [1:0]  fc_a;
  logic [3:0]  fa_a;
  logic        ea_b, eu_b, ed_b, fv_b;
  logic [1:0]  cnt_b;
  logic [1:0]  fc_b;
  logic [3:0]  fa_b;
  logic        ea_c, eu_c, ed_c, fv_c;
  logic [15:0] cnt_c;
  logic [1:0]  fc_c;
  logic [3:0]  fa_c;

  ram_access_checker u_a (
    .clk(clk), .reset(reset), .en(en && (sel == 0)),
    .wr(wr), .addr(addr), .datain(datain),
    .dataout(dataout), .clr(clr),
    .err_addr(ea_a), .err_uninit(eu_a), .err_data(ed_a),
    .err_cnt(cnt_a), .first_err_vld(fv_a),
    .first_err_code(fc_a), .first_err_addr(fa_a)
  );

  ram_access_checker #(.CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .en(en && (sel == 1)),
    .wr(wr), .addr(addr), .datain(datain),
    .dataout(dataout), .clr(clr),
    .err_addr(ea_b), .err_uninit(eu_b), .err_data(ed_b),
    .err_cnt(cnt_b), .first_err_vld(fv_b),
    .first_err_code(fc_b), .first_err_addr(fa_b)
  );

  ram_access_checker #(.RD_LAT(3)) u_c (
    .clk(clk), .reset(reset), .en(en && (sel == 2)),
    .wr(wr), .addr(addr), .datain(datain),
    .dataout(dataout), .clr(clr),
    .err_addr(ea_c), .err_uninit(eu_c), .err_data(ed_c),
    .err_cnt(cnt_c), .first_err_vld(fv_c),
    .first_err_code(fc_c), .first_err_addr(fa_c)
  );

  always @(posedge clk) begin
    exp_t        x;
    logic [2:0]  p;
    logic [15:0] c;
    logic        v;
    logic [1:0]  cd;
    logic [3:0]  fa;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      if (x.sel == 0) begin
        p = {ea_a, eu_a, ed_a}; c = cnt_a;
        v = fv_a; cd = fc_a; fa = fa_a;
      end else if (x.sel == 1) begin
        p = {ea_b, eu_b, ed_b}; c = {14'd0, cnt_b};
        v = fv_b; cd = fc_b; fa = fa_b;
      end else begin
        p = {ea_c, eu_c, ed_c}; c = cnt_c;
        v = fv_c; cd = fc_c; fa = fa_c;
      end
      if (!x.vld) begin
        cd = x.code;
        fa = x.fa;
      end
      n_run++;
      if ({p, c, v, cd, fa} !==
          {x.pul, x.cnt, x.vld, x.code, x.fa}) begin
        n_fail++;
        $display("FAIL %s: got pul=%b cnt=%0d vld=%b code=%b fa=%0d, want pul=%b cnt=%0d vld=%b code=%b fa=%0d",
                 x.tag, p, c, v, cd, fa,
                 x.pul, x.cnt, x.vld, x.code, x.fa);
      end
    end
  end

  function automatic exp_t ex(string t, logic [2:0] p, int c,
                              logic v, logic [1:0] cd,
                              logic [3:0] fa);
    exp_t r;
    r.tag = t; r.sel = sel; r.pul = p; r.cnt = 16'(c);
    r.vld = v; r.code = cd; r.fa = fa;
    return r;
  endfunction

  task automatic tick(input exp_t x);
    q.push_back(x);
    @(negedge clk);
    en = 0; wr = 0; clr = 0; reset = 0;
  endtask

  task automatic acc(input logic w, input logic [3:0] a,
                     input logic [7:0] d);
    en = 1; wr = w; addr = a; datain = d;
  endtask

  localparam logic [2:0] P0 = 3'b000;
  localparam logic [2:0] PA = 3'b100;
  localparam logic [2:0] PU = 3'b010;
  localparam logic [2:0] PD = 3'b001;
  localparam logic [2:0] PAD = 3'b101;

  initial begin
    @(negedge clk);
    sel = 0;
    reset = 1; tick(ex("rst", P0, 0, 0, 0, 0));

    acc(1, 3, 8'hA5); tick(ex("s1_wr", P0, 0, 0, 0, 0));
    acc(0, 3, 0);     tick(ex("s1_rd", P0, 0, 0, 0, 0));
    dataout = 8'hA5;  tick(ex("s1_cmp", P0, 0, 0, 0, 0));

    reset = 1; tick(ex("s2_rst", P0, 0, 0, 0, 0));
    acc(0, 5, 0);     tick(ex("s2_rd", P0, 0, 0, 0, 0));
    tick(ex("s2_uninit", PU, 1, 1, 2'b10, 5));
    tick(ex("s2_hold", P0, 1, 1, 2'b10, 5));

    reset = 1; tick(ex("s3_rst", P0, 0, 0, 0, 0));
    acc(1, 2, 8'h3C); tick(ex("s3_wr", P0, 0, 0, 0, 0));
    acc(0, 2, 0);     tick(ex("s3_rd", P0, 0, 0, 0, 0));
    dataout = 8'h3D;  tick(ex("s3_data", PD, 1, 1, 2'b11, 2));
    tick(ex("s3_hold", P0, 1, 1, 2'b11, 2));

    reset = 1; tick(ex("s4_rst", P0, 0, 0, 0, 0));
    acc(1, 9, 8'h11);  tick(ex("s4_wr9", P0, 0, 0, 0, 0));
    acc(1, 12, 8'h55); tick(ex("s4_wr12", PA, 1, 1, 2'b01, 12));
    acc(0, 12, 0);     tick(ex("s4_rd12", PA, 2, 1, 2'b01, 12));
    acc(0, 9, 0);      tick(ex("s4_rd9", P0, 2, 1, 2'b01, 12));
    dataout = 8'h11;   tick(ex("s4_cmp9", P0, 2, 1, 2'b01, 12));

    reset = 1; tick(ex("s5_rst", P0, 0, 0, 0, 0));
    acc(1, 4, 8'h20); tick(ex("s5_wr", P0, 0, 0, 0, 0));
    acc(0, 4, 0);     tick(ex("s5_rd", P0, 0, 0, 0, 0));
    dataout = 8'h21;
    acc(0, 15, 0);    tick(ex("s5_both", PAD, 2, 1, 2'b11, 4));
    tick(ex("s5_hold", P0, 2, 1, 2'b11, 4));
    acc(0, 15, 0); clr = 1;
    tick(ex("s5_clr", PA, 0, 0, 0, 0));
    acc(0, 14, 0);    tick(ex("s5_after", PA, 1, 1, 2'b01, 14));

    sel = 1;
    reset = 1; tick(ex("s6_rst", P0, 0, 0, 0, 0));
    acc(0, 13, 0); tick(ex("s6_e1", PA, 1, 1, 2'b01, 13));
    acc(0, 13, 0); tick(ex("s6_e2", PA, 2, 1, 2'b01, 13));
    acc(0, 13, 0); tick(ex("s6_e3", PA, 3, 1, 2'b01, 13));
    acc(0, 13, 0); tick(ex("s6_e4", PA, 3, 1, 2'b01, 13));
    acc(0, 13, 0); tick(ex("s6_e5", PA, 3, 1, 2'b01, 13));
    clr = 1;       tick(ex("s6_clr", P0, 0, 0, 0, 0));

    sel = 2;
    reset = 1; tick(ex("s7_rst", P0, 0, 0, 0, 0));
    acc(1, 1, 8'h77); tick(ex("s7_wr77", P0, 0, 0, 0, 0));
    acc(0, 1, 0);     tick(ex("s7_rd", P0, 0, 0, 0, 0));
    acc(1, 1, 8'h00); tick(ex("s7_wr00", P0, 0, 0, 0, 0));
    tick(ex("s7_l2", P0, 0, 0, 0, 0));
    dataout = 8'h77;  tick(ex("s7_cmp", P0, 0, 0, 0, 0));
    acc(0, 1, 0);     tick(ex("s7_rd2", P0, 0, 0, 0, 0));
    tick(ex("s7_w1", P0, 0, 0, 0, 0));
    tick(ex("s7_w2", P0, 0, 0, 0, 0));
    tick(ex("s7_data", PD, 1, 1, 2'b11, 1));

    reset = 1; tick(ex("s8c_rst", P0, 0, 0, 0, 0));
    acc(0, 7, 0); tick(ex("s8c_rd", P0, 0, 0, 0, 0));
    reset = 1;    tick(ex("s8c_mid", P0, 0, 0, 0, 0));
    tick(ex("s8c_i1", P0, 0, 0, 0, 0));
    tick(ex("s8c_i2", P0, 0, 0, 0, 0));
    tick(ex("s8c_i3", P0, 0, 0, 0, 0));

    sel = 0;
    reset = 1; tick(ex("s8a_rst", P0, 0, 0, 0, 0));
    acc(1, 6, 8'h44); tick(ex("s8a_wr", P0, 0, 0, 0, 0));
    acc(0, 6, 0);     tick(ex("s8a_rd", P0, 0, 0, 0, 0));
    dataout = 8'h00;
    reset = 1;        tick(ex("s8a_mid", P0, 0, 0, 0, 0));
    tick(ex("s8a_i1", P0, 0, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
